// File: rtl/issue_queue_dispatcher_pkg.sv
// Shared encodings for the issue stage: instruction classes, ROB signal codes,
// default widths and small class-decoding helpers.
package issue_queue_dispatcher_pkg;

    localparam int DEFAULT_DEPTH    = 4;
    localparam int DEFAULT_XLEN     = 32;
    localparam int DEFAULT_ROB_ID_W = 4;
    localparam int DEFAULT_REG_ID_W = 5;
    localparam int DEFAULT_OP_W     = 6;

    typedef enum logic [1:0] {
        CLASS_NORMAL = 2'd0,
        CLASS_LOAD   = 2'd1,
        CLASS_STORE  = 2'd2,
        CLASS_BRANCH = 2'd3
    } inst_class_e;

    localparam logic [1:0] ISSUER_TO_ROB_SIGNAL_NORMAL = 2'd0;
    localparam logic [1:0] ISSUER_TO_ROB_SIGNAL_LOAD   = 2'd1;
    localparam logic [1:0] ISSUER_TO_ROB_SIGNAL_STORE  = 2'd2;
    localparam logic [1:0] ISSUER_TO_ROB_SIGNAL_BRANCH = 2'd3;

    function automatic logic is_mem_class(input logic [1:0] cls);
        return (cls == CLASS_LOAD) || (cls == CLASS_STORE);
    endfunction

    // NORMAL covers register-register ops; the decoder zeroes rs2 for immediates,
    // and x0 never carries a dependency, so only loads lack a second source.
    function automatic logic has_rs2(input logic [1:0] cls);
        return cls != CLASS_LOAD;
    endfunction

    function automatic logic [1:0] to_rob_signal(input logic [1:0] cls);
        logic [1:0] sig;
        case (cls)
            CLASS_LOAD:   sig = ISSUER_TO_ROB_SIGNAL_LOAD;
            CLASS_STORE:  sig = ISSUER_TO_ROB_SIGNAL_STORE;
            CLASS_BRANCH: sig = ISSUER_TO_ROB_SIGNAL_BRANCH;
            default:      sig = ISSUER_TO_ROB_SIGNAL_NORMAL;
        endcase
        return sig;
    endfunction

endpackage

// File: rtl/issue_queue_dispatcher_issue_fifo.sv
// Power-of-two FIFO holding packed decoded instructions; the head entry is
// presented combinationally and flush empties it synchronously.
module issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/issue_queue_dispatcher.sv
// Issue stage: queues decoded instructions, renames the head's operands
// (reg file, ROB, CDB bypass) and steers it to the RS or the LS buffer.
module issue_queue_dispatcher
    import issue_queue_dispatcher_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int XLEN     = DEFAULT_XLEN,
    parameter int ROB_ID_W = DEFAULT_ROB_ID_W,
    parameter int REG_ID_W = DEFAULT_REG_ID_W,
    parameter int OP_W     = DEFAULT_OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_op,
    input  logic [REG_ID_W-1:0] in_rd,
    input  logic [REG_ID_W-1:0] in_rs1,
    input  logic [REG_ID_W-1:0] in_rs2,
    input  logic [XLEN-1:0]     in_imm,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_next_pc,
    input  logic [1:0]          in_class,
    output logic [REG_ID_W-1:0] rs1_to_reg_file,
    output logic [REG_ID_W-1:0] rs2_to_reg_file,
    input  logic [XLEN-1:0]     vj_from_reg_file,
    input  logic [ROB_ID_W-1:0] qj_from_reg_file,
    input  logic [XLEN-1:0]     vk_from_reg_file,
    input  logic [ROB_ID_W-1:0] qk_from_reg_file,
    output logic [ROB_ID_W-1:0] qj_to_ro_buffer,
    output logic [ROB_ID_W-1:0] qk_to_ro_buffer,
    input  logic                valid_of_vj_from_ro_buffer,
    input  logic                valid_of_vk_from_ro_buffer,
    input  logic [XLEN-1:0]     vj_from_ro_buffer,
    input  logic [XLEN-1:0]     vk_from_ro_buffer,
    input  logic                cdb_valid,
    input  logic [ROB_ID_W-1:0] cdb_dest,
    input  logic [XLEN-1:0]     cdb_value,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic [ROB_ID_W-1:0] dest_from_ro_buffer,
    output logic                valid_to_ro_buffer,
    output logic [1:0]          signal_to_ro_buffer,
    output logic [REG_ID_W-1:0] rd_to_ro_buffer,
    output logic [XLEN-1:0]     pc_to_ro_buffer,
    output logic [XLEN-1:0]     next_pc_to_ro_buffer,
    output logic [REG_ID_W-1:0] rd_to_reg_file,
    output logic [ROB_ID_W-1:0] dest_to_reg_file,
    output logic [ROB_ID_W-1:0] dest_to_rs_station,
    output logic [OP_W-1:0]     op_to_rs_station,
    output logic [ROB_ID_W-1:0] qj_to_rs_station,
    output logic [ROB_ID_W-1:0] qk_to_rs_station,
    output logic [XLEN-1:0]     vj_to_rs_station,
    output logic [XLEN-1:0]     vk_to_rs_station,
    output logic [XLEN-1:0]     imm_to_rs_station,
    output logic [XLEN-1:0]     pc_to_rs_station,
    output logic [ROB_ID_W-1:0] dest_to_ls_buffer,
    output logic [OP_W-1:0]     op_to_ls_buffer,
    output logic [ROB_ID_W-1:0] qj_to_ls_buffer,
    output logic [ROB_ID_W-1:0] qk_to_ls_buffer,
    output logic [XLEN-1:0]     vj_to_ls_buffer,
    output logic [XLEN-1:0]     vk_to_ls_buffer,
    output logic [XLEN-1:0]     a_to_ls_buffer,
    output logic [XLEN-1:0]     pc_to_ls_buffer
);

    localparam int ENTRY_W = OP_W + 3 * REG_ID_W + 3 * XLEN + 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic [ENTRY_W-1:0]  push_entry, head_entry;
    logic [CNT_W-1:0]    count;
    logic                push, pop, head_is_mem;
    logic [OP_W-1:0]     h_op;
    logic [REG_ID_W-1:0] h_rd, h_rs1, h_rs2, rename_rd;
    logic [XLEN-1:0]     h_imm, h_pc, h_next_pc;
    logic [1:0]          h_class;
    logic [ROB_ID_W-1:0] qj_res, qk_res;
    logic [XLEN-1:0]     vj_res, vk_res;

    function automatic logic [ROB_ID_W+XLEN-1:0] resolve_operand(
        input logic [ROB_ID_W-1:0] reg_q,
        input logic [XLEN-1:0]     reg_v,
        input logic                rob_valid,
        input logic [XLEN-1:0]     rob_v,
        input logic                bus_valid,
        input logic [ROB_ID_W-1:0] bus_dest,
        input logic [XLEN-1:0]     bus_value
    );
        if (reg_q == '0)                       return {{ROB_ID_W{1'b0}}, reg_v};
        else if (rob_valid)                    return {{ROB_ID_W{1'b0}}, rob_v};
        else if (bus_valid && bus_dest == reg_q) return {{ROB_ID_W{1'b0}}, bus_value};
        else                                   return {reg_q, {XLEN{1'b0}}};
    endfunction

    assign push_entry = {in_op, in_rd, in_rs1, in_rs2, in_imm, in_pc, in_next_pc, in_class};
    assign {h_op, h_rd, h_rs1, h_rs2, h_imm, h_pc, h_next_pc, h_class} = head_entry;

    assign in_ready    = count < CNT_W'(DEPTH);
    assign push        = in_valid && in_ready && rdy && !flush;
    assign head_is_mem = is_mem_class(h_class);
    assign pop         = rdy && !flush && (count != '0) && !rob_full
                         && (head_is_mem ? !lsb_full : !rs_full);

    issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head_data (head_entry),
        .count     (count)
    );

    assign rs1_to_reg_file = h_rs1;
    assign rs2_to_reg_file = h_rs2;
    assign qj_to_ro_buffer = qj_from_reg_file;
    assign qk_to_ro_buffer = qk_from_reg_file;

    assign {qj_res, vj_res} = resolve_operand(qj_from_reg_file, vj_from_reg_file,
                                              valid_of_vj_from_ro_buffer, vj_from_ro_buffer,
                                              cdb_valid, cdb_dest, cdb_value);
    assign {qk_res, vk_res} = has_rs2(h_class)
        ? resolve_operand(qk_from_reg_file, vk_from_reg_file,
                          valid_of_vk_from_ro_buffer, vk_from_ro_buffer,
                          cdb_valid, cdb_dest, cdb_value)
        : '0;

    // Stores never write a register; x0 writes are architecturally discarded.
    assign rename_rd = (h_class == CLASS_STORE || h_rd == '0) ? '0 : h_rd;

    logic                valid_q, valid_d;
    logic [1:0]          signal_q, signal_d;
    logic [REG_ID_W-1:0] rd_q, rd_d;
    logic [ROB_ID_W-1:0] rf_dest_q, rf_dest_d, rs_dest_q, rs_dest_d, lsb_dest_q, lsb_dest_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ROB_ID_W-1:0] qj_q, qj_d, qk_q, qk_d;
    logic [XLEN-1:0]     vj_q, vj_d, vk_q, vk_d, imm_q, imm_d, pc_q, pc_d, npc_q, npc_d;

    // Dest/valid/rd are one-cycle pulses; payload fields hold until the next dispatch.
    always_comb begin
        valid_d    = valid_q;
        signal_d   = signal_q;
        rd_d       = rd_q;
        rf_dest_d  = rf_dest_q;
        rs_dest_d  = rs_dest_q;
        lsb_dest_d = lsb_dest_q;
        op_d       = op_q;
        qj_d       = qj_q;
        qk_d       = qk_q;
        vj_d       = vj_q;
        vk_d       = vk_q;
        imm_d      = imm_q;
        pc_d       = pc_q;
        npc_d      = npc_q;
        if (flush) begin
            valid_d    = 1'b0;
            signal_d   = '0;
            rd_d       = '0;
            rf_dest_d  = '0;
            rs_dest_d  = '0;
            lsb_dest_d = '0;
            op_d       = '0;
            qj_d       = '0;
            qk_d       = '0;
            vj_d       = '0;
            vk_d       = '0;
            imm_d      = '0;
            pc_d       = '0;
            npc_d      = '0;
        end else if (rdy) begin
            valid_d    = 1'b0;
            rd_d       = '0;
            rf_dest_d  = '0;
            rs_dest_d  = '0;
            lsb_dest_d = '0;
            if (pop) begin
                valid_d    = 1'b1;
                signal_d   = to_rob_signal(h_class);
                rd_d       = rename_rd;
                rf_dest_d  = dest_from_ro_buffer;
                rs_dest_d  = head_is_mem ? '0 : dest_from_ro_buffer;
                lsb_dest_d = head_is_mem ? dest_from_ro_buffer : '0;
                op_d       = h_op;
                qj_d       = qj_res;
                qk_d       = qk_res;
                vj_d       = vj_res;
                vk_d       = vk_res;
                imm_d      = h_imm;
                pc_d       = h_pc;
                npc_d      = h_next_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            signal_q   <= '0;
            rd_q       <= '0;
            rf_dest_q  <= '0;
            rs_dest_q  <= '0;
            lsb_dest_q <= '0;
            op_q       <= '0;
            qj_q       <= '0;
            qk_q       <= '0;
            vj_q       <= '0;
            vk_q       <= '0;
            imm_q      <= '0;
            pc_q       <= '0;
            npc_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            signal_q   <= signal_d;
            rd_q       <= rd_d;
            rf_dest_q  <= rf_dest_d;
            rs_dest_q  <= rs_dest_d;
            lsb_dest_q <= lsb_dest_d;
            op_q       <= op_d;
            qj_q       <= qj_d;
            qk_q       <= qk_d;
            vj_q       <= vj_d;
            vk_q       <= vk_d;
            imm_q      <= imm_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
        end
    end

    assign valid_to_ro_buffer   = valid_q;
    assign signal_to_ro_buffer  = signal_q;
    assign rd_to_ro_buffer      = rd_q;
    assign pc_to_ro_buffer      = pc_q;
    assign next_pc_to_ro_buffer = npc_q;
    assign rd_to_reg_file       = rd_q;
    assign dest_to_reg_file     = rf_dest_q;
    assign dest_to_rs_station   = rs_dest_q;
    assign op_to_rs_station     = op_q;
    assign qj_to_rs_station     = qj_q;
    assign qk_to_rs_station     = qk_q;
    assign vj_to_rs_station     = vj_q;
    assign vk_to_rs_station     = vk_q;
    assign imm_to_rs_station    = imm_q;
    assign pc_to_rs_station     = pc_q;
    assign dest_to_ls_buffer    = lsb_dest_q;
    assign op_to_ls_buffer      = op_q;
    assign qj_to_ls_buffer      = qj_q;
    assign qk_to_ls_buffer      = qk_q;
    assign vj_to_ls_buffer      = vj_q;
    assign vk_to_ls_buffer      = vk_q;
    assign a_to_ls_buffer       = imm_q;
    assign pc_to_ls_buffer      = pc_q;

endmodule

// File: tb/tb_issue_queue_dispatcher.sv
// Directed bench for issue_queue_dispatcher: a scoreboard of expected dispatches
// is filled as instructions are pushed and drained as the DUT emits them.
module tb_issue_queue_dispatcher;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        in_valid, in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm, in_pc, in_next_pc;
    logic [1:0]  in_class;
    logic [4:0]  rs1_to_reg_file, rs2_to_reg_file;
    logic [31:0] vj_from_reg_file, vk_from_reg_file;
    logic [3:0]  qj_from_reg_file, qk_from_reg_file;
    logic [3:0]  qj_to_ro_buffer, qk_to_ro_buffer;
    logic        valid_of_vj_from_ro_buffer, valid_of_vk_from_ro_buffer;
    logic [31:0] vj_from_ro_buffer, vk_from_ro_buffer;
    logic        cdb_valid;
    logic [3:0]  cdb_dest;
    logic [31:0] cdb_value;
    logic        rob_full, rs_full, lsb_full;
    logic [3:0]  dest_from_ro_buffer;
    logic        valid_to_ro_buffer;
    logic [1:0]  signal_to_ro_buffer;
    logic [4:0]  rd_to_ro_buffer, rd_to_reg_file;
    logic [31:0] pc_to_ro_buffer, next_pc_to_ro_buffer;
    logic [3:0]  dest_to_reg_file;
    logic [3:0]  dest_to_rs_station, qj_to_rs_station, qk_to_rs_station;
    logic [5:0]  op_to_rs_station, op_to_ls_buffer;
    logic [31:0] vj_to_rs_station, vk_to_rs_station, imm_to_rs_station, pc_to_rs_station;
    logic [3:0]  dest_to_ls_buffer, qj_to_ls_buffer, qk_to_ls_buffer;
    logic [31:0] vj_to_ls_buffer, vk_to_ls_buffer, a_to_ls_buffer, pc_to_ls_buffer;

    always #5 clk = ~clk;

    issue_queue_dispatcher #(
        .DEPTH(4), .XLEN(32), .ROB_ID_W(4), .REG_ID_W(5), .OP_W(6)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .in_next_pc(in_next_pc), .in_class(in_class),
        .rs1_to_reg_file(rs1_to_reg_file), .rs2_to_reg_file(rs2_to_reg_file),
        .vj_from_reg_file(vj_from_reg_file), .qj_from_reg_file(qj_from_reg_file),
        .vk_from_reg_file(vk_from_reg_file), .qk_from_reg_file(qk_from_reg_file),
        .qj_to_ro_buffer(qj_to_ro_buffer), .qk_to_ro_buffer(qk_to_ro_buffer),
        .valid_of_vj_from_ro_buffer(valid_of_vj_from_ro_buffer),
        .valid_of_vk_from_ro_buffer(valid_of_vk_from_ro_buffer),
        .vj_from_ro_buffer(vj_from_ro_buffer), .vk_from_ro_buffer(vk_from_ro_buffer),
        .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
        .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
        .dest_from_ro_buffer(dest_from_ro_buffer),
        .valid_to_ro_buffer(valid_to_ro_buffer), .signal_to_ro_buffer(signal_to_ro_buffer),
        .rd_to_ro_buffer(rd_to_ro_buffer), .pc_to_ro_buffer(pc_to_ro_buffer),
        .next_pc_to_ro_buffer(next_pc_to_ro_buffer),
        .rd_to_reg_file(rd_to_reg_file), .dest_to_reg_file(dest_to_reg_file),
        .dest_to_rs_station(dest_to_rs_station), .op_to_rs_station(op_to_rs_station),
        .qj_to_rs_station(qj_to_rs_station), .qk_to_rs_station(qk_to_rs_station),
        .vj_to_rs_station(vj_to_rs_station), .vk_to_rs_station(vk_to_rs_station),
        .imm_to_rs_station(imm_to_rs_station), .pc_to_rs_station(pc_to_rs_station),
        .dest_to_ls_buffer(dest_to_ls_buffer), .op_to_ls_buffer(op_to_ls_buffer),
        .qj_to_ls_buffer(qj_to_ls_buffer), .qk_to_ls_buffer(qk_to_ls_buffer),
        .vj_to_ls_buffer(vj_to_ls_buffer), .vk_to_ls_buffer(vk_to_ls_buffer),
        .a_to_ls_buffer(a_to_ls_buffer), .pc_to_ls_buffer(pc_to_ls_buffer)
    );

    typedef struct {
        logic        is_mem;
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [5:0]  op;
        logic [31:0] pc, imm, vj, vk;
        logic [3:0]  qj, qk;
        logic        chk_vk;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  qtab [32];
    logic [15:0] robvalid;
    logic [3:0]  rob_tag;

    // Reg file and ROB lookups respond combinationally from simple tables.
    always_comb begin
        qj_from_reg_file           = qtab[rs1_to_reg_file];
        qk_from_reg_file           = qtab[rs2_to_reg_file];
        vj_from_reg_file           = 32'h1000 + 32'(rs1_to_reg_file);
        vk_from_reg_file           = 32'h2000 + 32'(rs2_to_reg_file);
        valid_of_vj_from_ro_buffer = robvalid[qj_to_ro_buffer];
        valid_of_vk_from_ro_buffer = robvalid[qk_to_ro_buffer];
        vj_from_ro_buffer          = 32'h3000 + 32'(qj_to_ro_buffer);
        vk_from_ro_buffer          = 32'h3000 + 32'(qk_to_ro_buffer);
        dest_from_ro_buffer        = rob_tag;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_resolve(input logic [3:0] q, input logic [31:0] regv,
                                          output logic [3:0] qo, output logic [31:0] vo);
        if (q == 4'd0) begin
            qo = 4'd0; vo = regv;
        end else if (robvalid[q]) begin
            qo = 4'd0; vo = 32'h3000 + 32'(q);
        end else if (cdb_valid && cdb_dest == q) begin
            qo = 4'd0; vo = cdb_value;
        end else begin
            qo = q; vo = 32'd0;
        end
    endfunction

    // Compare whatever the DUT emitted on the edge just past against the scoreboard head.
    task automatic checkOutput();
        exp_t e;
        if (valid_to_ro_buffer) begin
            if (sb.size() == 0) begin
                chk("unexpected_dispatch", 64'(valid_to_ro_buffer), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("dest_rs", 64'(dest_to_rs_station), 64'(e.is_mem ? 4'd0 : rob_tag));
                chk("dest_lsb", 64'(dest_to_ls_buffer), 64'(e.is_mem ? rob_tag : 4'd0));
                chk("dest_rf", 64'(dest_to_reg_file), 64'(rob_tag));
                chk("rd_rf", 64'(rd_to_reg_file), 64'(e.rd));
                chk("signal", 64'(signal_to_ro_buffer), 64'(e.cls));
                chk("pc_rob", 64'(pc_to_ro_buffer), 64'(e.pc));
                if (e.is_mem) begin
                    chk("lsb_pc", 64'(pc_to_ls_buffer), 64'(e.pc));
                    chk("lsb_a", 64'(a_to_ls_buffer), 64'(e.imm));
                    chk("lsb_qj", 64'(qj_to_ls_buffer), 64'(e.qj));
                    chk("lsb_qk", 64'(qk_to_ls_buffer), 64'(e.qk));
                    if (e.qj == 4'd0) chk("lsb_vj", 64'(vj_to_ls_buffer), 64'(e.vj));
                    if (e.chk_vk && e.qk == 4'd0) chk("lsb_vk", 64'(vk_to_ls_buffer), 64'(e.vk));
                end else begin
                    chk("rs_pc", 64'(pc_to_rs_station), 64'(e.pc));
                    chk("rs_op", 64'(op_to_rs_station), 64'(e.op));
                    chk("rs_imm", 64'(imm_to_rs_station), 64'(e.imm));
                    chk("rs_qj", 64'(qj_to_rs_station), 64'(e.qj));
                    chk("rs_qk", 64'(qk_to_rs_station), 64'(e.qk));
                    if (e.qj == 4'd0) chk("rs_vj", 64'(vj_to_rs_station), 64'(e.vj));
                    if (e.chk_vk && e.qk == 4'd0) chk("rs_vk", 64'(vk_to_rs_station), 64'(e.vk));
                end
            end
            rob_tag = (rob_tag == 4'd15) ? 4'd1 : rob_tag + 4'd1;
        end else begin
            chk("idle_pulses", 64'({dest_to_rs_station, dest_to_ls_buffer, dest_to_reg_file, rd_to_reg_file}), 64'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Present one instruction for one cycle; record its expected dispatch if it should be accepted.
    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [1:0] cls, input logic [31:0] pc,
                                 input logic expect_accept);
        exp_t e;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_class = cls;
        in_pc = pc; in_imm = pc ^ 32'h55; in_next_pc = pc + 32'd4;
        chk("in_ready", 64'(in_ready), 64'(expect_accept));
        if (expect_accept) begin
            e.is_mem = (cls == 2'd1) || (cls == 2'd2);
            e.cls    = cls;
            e.rd     = (cls == 2'd2 || rd == 5'd0) ? 5'd0 : rd;
            e.op     = op;
            e.pc     = pc;
            e.imm    = pc ^ 32'h55;
            model_resolve(qtab[rs1], 32'h1000 + 32'(rs1), e.qj, e.vj);
            if (cls == 2'd1) begin
                e.qk = 4'd0; e.vk = 32'd0; e.chk_vk = 1'b0;
            end else begin
                model_resolve(qtab[rs2], 32'h2000 + 32'(rs2), e.qk, e.vk);
                e.chk_vk = 1'b1;
            end
            sb.push_back(e);
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_class = '0;
        in_imm = '0; in_pc = '0; in_next_pc = '0;
        cdb_valid = 1'b0; cdb_dest = '0; cdb_value = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        robvalid = '0; rob_tag = 4'd1;
        for (int i = 0; i < 32; i++) qtab[i] = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(valid_to_ro_buffer), 64'd0);
        chk("reset_dests", 64'({dest_to_rs_station, dest_to_ls_buffer, dest_to_reg_file, rd_to_reg_file}), 64'd0);
        rst = 1'b0;
        step();

        $display("[TB] reset with queued entries");
        rs_full = 1'b1;
        applyStimulus(6'h13, 5'd1, 5'd2, 5'd0, 2'd0, 32'h100, 1'b1);
        applyStimulus(6'h13, 5'd2, 5'd3, 5'd0, 2'd0, 32'h104, 1'b1);
        applyStimulus(6'h13, 5'd3, 5'd4, 5'd0, 2'd0, 32'h108, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_dests", 64'({dest_to_rs_station, dest_to_ls_buffer, dest_to_reg_file}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        rs_full = 1'b0;
        repeat (4) step();

        $display("[TB] fill under rs_full then release");
        rs_full = 1'b1;
        for (int i = 0; i < 5; i++)
            applyStimulus(6'h13, 5'(i + 1), 5'(i + 2), 5'd0, 2'd0, 32'h200 + 32'(4 * i), i < 4);
        rs_full = 1'b0;
        waitDrain(10);
        step();

        $display("[TB] load/store blocked by lsb_full");
        qtab[6] = 4'd7;
        lsb_full = 1'b1;
        applyStimulus(6'h03, 5'd3, 5'd2, 5'd6, 2'd1, 32'h300, 1'b1);
        applyStimulus(6'h23, 5'd9, 5'd4, 5'd6, 2'd2, 32'h304, 1'b1);
        repeat (3) step();
        lsb_full = 1'b0;
        waitDrain(10);
        qtab[6] = 4'd0;

        $display("[TB] operand resolve via cdb, rob and pass-through");
        qtab[5] = 4'd3; qtab[7] = 4'd4; qtab[8] = 4'd9;
        robvalid[4] = 1'b1;
        cdb_valid = 1'b1; cdb_dest = 4'd3; cdb_value = 32'hDEAD;
        applyStimulus(6'h33, 5'd10, 5'd5, 5'd6, 2'd0, 32'h400, 1'b1);
        applyStimulus(6'h33, 5'd11, 5'd7, 5'd5, 2'd0, 32'h404, 1'b1);
        applyStimulus(6'h63, 5'd0, 5'd8, 5'd7, 2'd3, 32'h408, 1'b1);
        waitDrain(10);
        cdb_valid = 1'b0; robvalid = '0;
        qtab[5] = 4'd0; qtab[7] = 4'd0; qtab[8] = 4'd0;

        $display("[TB] flush with push and dispatch");
        applyStimulus(6'h13, 5'd4, 5'd1, 5'd0, 2'd0, 32'h500, 1'b1);
        flush = 1'b1;
        in_valid = 1'b1; in_pc = 32'h504; in_class = 2'd0;
        sb.delete();
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (4) step();

        $display("[TB] steady push+pop with pointer wrap");
        rs_full = 1'b1;
        for (int i = 0; i < 4; i++)
            applyStimulus(6'h13, 5'(i + 1), 5'(i + 1), 5'd0, 2'd0, 32'h600 + 32'(4 * i), 1'b1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        rs_full = 1'b0;
        step();
        for (int i = 0; i < 8; i++)
            applyStimulus(6'h13, 5'(i + 5), 5'(i + 3), 5'd0, 2'd0, 32'h700 + 32'(4 * i), 1'b1);
        waitDrain(10);
        repeat (2) step();
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
